// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg: shared constants and width helper for the prefetch FIFO
package sync_fifo_pkg;
  localparam int RD_LAT_MAX = 3;
  localparam int OB_MAX = RD_LAT_MAX + 1;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/sync_prefetch_fifo_obuf.sv
// prefetch_obuf: shift-register output buffer; overflow is prevented by upstream credits
module prefetch_obuf import sync_fifo_pkg::*; #(
  parameter int W = 18,
  parameter int OB = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic         empty
);
  localparam int CW = clog2(OB + 1);
  logic [W-1:0] dat_q [OB];
  logic [W-1:0] dat_d [OB];
  logic [CW-1:0] cnt_q, cnt_d, wi;
  always_comb begin
    wi = cnt_q - CW'(pop);
    cnt_d = clr ? '0 : cnt_q + CW'(push) - CW'(pop);
    for (int i = 0; i < OB - 1; i++) dat_d[i] = pop ? dat_q[i+1] : dat_q[i];
    dat_d[OB-1] = dat_q[OB-1];
    for (int i = 0; i < OB; i++) if (push && wi == CW'(i)) dat_d[i] = din;
  end
  assign head = dat_q[0];
  assign empty = cnt_q == '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  always_ff @(posedge clk) dat_q <= dat_d;
endmodule

// File: rtl/sync_prefetch_fifo.sv
// sync_prefetch_fifo: FWFT FIFO over a RD_LAT-cycle storage read, with credit-sized output buffer
module sync_prefetch_fifo import sync_fifo_pkg::*; #(
  parameter int W = 18,
  parameter int D = 512,
  parameter int RD_LAT = 1,
  parameter int AF_LEVEL = D - 4,
  parameter int AE_LEVEL = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 data_in_valid,
  input  logic [W-1:0]         data_in,
  output logic                 data_in_ready,
  input  logic                 data_out_ready,
  output logic [W-1:0]         data_out,
  output logic                 data_out_valid,
  output logic [clog2(D)+1:0]  level,
  output logic                 almost_full,
  output logic                 almost_empty
);
  localparam int AW = clog2(D);
  localparam int PW = AW + 1;
  localparam int LW = AW + 2;
  localparam int OB = RD_LAT + 1;
  localparam int CW = clog2(OB_MAX + 1);
  localparam logic [PW-1:0] DEPTH = PW'(D);
  localparam logic [CW-1:0] OB_C = CW'(OB);
  localparam logic [LW-1:0] AF_C = LW'(AF_LEVEL);
  localparam logic [LW-1:0] AE_C = LW'(AE_LEVEL);
  logic [W-1:0] mem [D];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, mem_cnt;
  logic [CW-1:0] ob_cnt_q, ob_cnt_d;
  logic [LW-1:0] level_q, level_d;
  logic [RD_LAT-1:0] pv_q, pv_d;
  logic [W-1:0] pd_q [RD_LAT];
  logic [W-1:0] pd_d [RD_LAT];
  logic af_q, af_d, ae_q, ae_d, push, pop, rd_en, ob_empty;
  always_comb begin
    mem_cnt = wr_ptr_q - rd_ptr_q;
    data_in_ready = mem_cnt != DEPTH && !flush;
    data_out_valid = !ob_empty && !flush;
    push = data_in_valid && data_in_ready;
    pop = data_out_valid && data_out_ready;
    // a pop returns its credit in the same cycle, keeping 1 word/cycle at any latency
    rd_en = mem_cnt != '0 && (ob_cnt_q < OB_C || pop);
    wr_ptr_d = flush ? '0 : wr_ptr_q + PW'(push);
    rd_ptr_d = flush ? '0 : rd_ptr_q + PW'(rd_en);
    ob_cnt_d = flush ? '0 : ob_cnt_q + CW'(rd_en) - CW'(pop);
    level_d = flush ? '0 : level_q + LW'(push) - LW'(pop);
    af_d = level_d >= AF_C;
    ae_d = level_d <= AE_C;
    pd_d[0] = rd_en ? mem[rd_ptr_q[AW-1:0]] : pd_q[0];
    pv_d[0] = rd_en && !flush;
    for (int i = 1; i < RD_LAT; i++) begin
      pd_d[i] = pd_q[i-1];
      pv_d[i] = pv_q[i-1] && !flush;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ob_cnt_q <= '0;
      level_q <= '0;
      pv_q <= '0;
      af_q <= 1'b0;
      ae_q <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ob_cnt_q <= ob_cnt_d;
      level_q <= level_d;
      pv_q <= pv_d;
      af_q <= af_d;
      ae_q <= ae_d;
    end
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q[AW-1:0]] <= data_in;
    pd_q <= pd_d;
  end
  prefetch_obuf #(.W(W), .OB(OB)) u_obuf (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush),
    .push  (pv_q[RD_LAT-1]),
    .pop   (pop),
    .din   (pd_q[RD_LAT-1]),
    .head  (data_out),
    .empty (ob_empty)
  );
  assign level = level_q;
  assign almost_full = af_q;
  assign almost_empty = ae_q;
endmodule

// File: tb/tb_sync_prefetch_fifo.sv
// tb_sync_prefetch_fifo: table vectors plus corner-case sequences, scoreboard-checked output
module tb_sync_prefetch_fifo;
  localparam int W = 18, D = 8, RD_LAT = 3, AF = D - 4, AE = 2, LW = $clog2(D) + 2;
  localparam int OB = RD_LAT + 1;
  typedef struct {
    logic         vin;
    logic [W-1:0] din;
    logic         rdy;
    int           exp_lvl;
    logic         exp_ov;
  } vec_t;
  logic clk = 0, rst_n = 1, flush = 0, vin = 0, rdy = 0;
  logic [W-1:0] din = '0, dout;
  logic iready, ovalid, af, ae;
  logic [LW-1:0] lvl;
  int n_vec = 0, n_err = 0, lvl_m = 0;
  logic [W-1:0] sb [$];
  vec_t tbl [15];

  always #5 clk = ~clk;

  sync_prefetch_fifo #(.W(W), .D(D), .RD_LAT(RD_LAT), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .flush          (flush),
    .data_in_valid  (vin),
    .data_in        (din),
    .data_in_ready  (iready),
    .data_out_ready (rdy),
    .data_out       (dout),
    .data_out_valid (ovalid),
    .level          (lvl),
    .almost_full    (af),
    .almost_empty   (ae)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // observe handshakes just after the inputs settle, then cross one rising edge
  task automatic tick();
    logic p, q;
    #1;
    p = vin && iready;
    q = ovalid && rdy;
    if (q) begin
      if (sb.size() == 0) chk("pop_unexpected", 32'd1, 32'd0);
      else chk("data", 32'(dout), 32'(sb.pop_front()));
    end
    if (p) sb.push_back(din);
    if (flush) begin
      lvl_m = 0;
      sb.delete();
    end else lvl_m = lvl_m + int'(p) - int'(q);
    @(negedge clk);
    chk("level", 32'(lvl), lvl_m);
    chk("almost_full", 32'(af), 32'(lvl_m >= AF));
    chk("almost_empty", 32'(ae), 32'(lvl_m <= AE));
  endtask

  task automatic drain();
    vin = 0;
    rdy = 1;
    for (int i = 0; i < 40 && sb.size() > 0; i++) tick();
    chk("drain_left", sb.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    tbl = '{
      '{1'b1, 18'h00001, 1'b0, 1, 1'b0},
      '{1'b1, 18'h00002, 1'b0, 2, 1'b0},
      '{1'b1, 18'h00003, 1'b0, 3, 1'b0},
      '{1'b1, 18'h00004, 1'b0, 4, 1'b0},
      '{1'b0, 18'h00000, 1'b0, 4, 1'b1},
      '{1'b0, 18'h00000, 1'b1, 3, 1'b1},
      '{1'b0, 18'h00000, 1'b1, 2, 1'b1},
      '{1'b0, 18'h00000, 1'b1, 1, 1'b1},
      '{1'b0, 18'h00000, 1'b1, 0, 1'b0},
      '{1'b1, 18'h00005, 1'b1, 1, 1'b0},
      '{1'b0, 18'h00000, 1'b1, 1, 1'b0},
      '{1'b0, 18'h00000, 1'b1, 1, 1'b0},
      '{1'b0, 18'h00000, 1'b1, 1, 1'b0},
      '{1'b0, 18'h00000, 1'b1, 1, 1'b1},
      '{1'b0, 18'h00000, 1'b1, 0, 1'b0}
    };
    rst_n = 0;
    repeat (2) @(negedge clk);
    chk("rst_ov", 32'(ovalid), 0);
    chk("rst_iready", 32'(iready), 1);
    chk("rst_level", 32'(lvl), 0);
    chk("rst_af", 32'(af), 0);
    chk("rst_ae", 32'(ae), 1);
    rst_n = 1;
    @(negedge clk);

    for (int i = 0; i < 15; i++) begin
      vin = tbl[i].vin;
      din = tbl[i].din;
      rdy = tbl[i].rdy;
      tick();
      chk("tbl_level", 32'(lvl), tbl[i].exp_lvl);
      chk("tbl_ov", 32'(ovalid), 32'(tbl[i].exp_ov));
    end

    rdy = 0;
    for (int i = 0; i < 10; i++) begin
      vin = 1;
      din = W'(18'h100 + i);
      tick();
    end
    vin = 0;
    repeat (6) tick();
    chk("hold_level", 32'(lvl), 10);
    chk("hold_ob_cnt", 32'(dut.ob_cnt_q), OB);
    rdy = 1;
    for (int i = 0; i < 10; i++) begin
      chk("no_bubble", 32'(ovalid), 1);
      tick();
    end
    chk("burst_sb", sb.size(), 0);

    rdy = 0;
    vin = 1;
    acc = 0;
    for (int i = 0; i < 30; i++) begin
      if (!iready) break;
      din = W'($urandom);
      tick();
      acc++;
    end
    chk("fill_count", acc, D + OB);
    chk("full_level", 32'(lvl), D + OB);
    chk("full_af", 32'(af), 1);
    chk("held_refused", 32'(iready), 0);
    tick();
    chk("held_level", 32'(lvl), D + OB);
    rdy = 1;
    #1 chk("full_pushpop_ready", 32'(iready), 0);
    tick();
    chk("full_pushpop_level", 32'(lvl), D + OB - 1);
    drain();

    rdy = 0;
    vin = 1;
    for (int i = 0; i < 5; i++) begin
      din = W'($urandom);
      tick();
    end
    vin = 0;
    repeat (6) tick();
    rdy = 1;
    vin = 1;
    for (int i = 0; i < 50; i++) begin
      din = W'($urandom);
      tick();
      chk("steady_level", 32'(lvl), 5);
    end
    drain();

    rdy = 0;
    vin = 1;
    for (int i = 0; i < 6; i++) begin
      din = W'(18'h200 + i);
      tick();
    end
    flush = 1;
    rdy = 1;
    din = 18'h2FF;
    #1;
    chk("flush_iready", 32'(iready), 0);
    chk("flush_ov", 32'(ovalid), 0);
    tick();
    flush = 0;
    vin = 0;
    chk("post_flush_level", 32'(lvl), 0);
    chk("post_flush_ov", 32'(ovalid), 0);
    chk("post_flush_ae", 32'(ae), 1);
    repeat (6) begin
      tick();
      chk("flush_discard", 32'(ovalid), 0);
    end
    rdy = 0;
    vin = 1;
    din = 18'h30ABC;
    tick();
    vin = 0;
    for (int k = 1; k <= RD_LAT + 1; k++) begin
      tick();
      chk("first_word_latency", 32'(ovalid), 32'(k == RD_LAT + 1));
    end
    drain();

    rdy = 1;
    vin = 1;
    for (int i = 0; i < 5; i++) begin
      din = W'($urandom);
      tick();
    end
    chk("pre_reset_ov", 32'(ovalid), 1);
    #2 rst_n = 0;
    #1;
    chk("async_ov", 32'(ovalid), 0);
    chk("async_iready", 32'(iready), 1);
    chk("async_level", 32'(lvl), 0);
    chk("async_af", 32'(af), 0);
    chk("async_ae", 32'(ae), 1);
    sb.delete();
    lvl_m = 0;
    vin = 0;
    @(negedge clk);
    rst_n = 1;
    vin = 1;
    for (int i = 0; i < 3; i++) begin
      din = W'(18'h400 + i);
      tick();
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/sync_prefetch_fifo.md
# sync_prefetch_fifo

Single-clock, first-word-fall-through FIFO with a parametrised storage read latency. It generalises the team's two-stage prefetch scheme to any memory latency from 1 to 3 via a credit-sized output buffer, and adds an occupancy count, almost-full/almost-empty flags and a synchronous flush. It sits between streaming producers and consumers in the same clock domain, such as MAC receive to packet parser, with valid/ready handshakes on both sides.

## Interface
- `W`, 18: data width in bits.
- `D`, 512: storage depth in words. Must be a power of 2 and ≥ 4.
- `RD_LAT`, 1: storage read latency in cycles, from read enable to data registered. Legal range is 1..3.
- `AF_LEVEL`, D-4: `almost_full` asserts when `level` ≥ `AF_LEVEL`.
- `AE_LEVEL`, 2: `almost_empty` asserts when `level` ≤ `AE_LEVEL`.
- `clk`  in  1  the only clock; all logic is on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `flush`  in  1  synchronous clear of all contents.
- `data_in_valid`  in  1  producer offers `data_in`.
- `data_in`  in  W  write data.
- `data_in_ready`  out  1  FIFO accepts a word this cycle.
- `data_out_ready`  in  1  consumer accepts `data_out`.
- `data_out`  out  W  head word. Valid only while `data_out_valid` is high.
- `data_out_valid`  out  1  head word present.
- `level`  out  clog2(D)+2  words held in storage plus words in the read pipeline plus words in the output buffer.
- `almost_full`  out  1  registered threshold flag.
- `almost_empty`  out  1  registered threshold flag.

## Operation
- Reset values:
  - pointers, pipeline valids and counts are all 0;
  - `data_out_valid`=0, `data_in_ready`=1, `level`=0;
  - `almost_full`=0, `almost_empty`=1;
  - `data_out` is don't-care.
- Storage is a D-entry array. `wr_ptr` and `rd_ptr` are each clog2(D)+1 bits wide and wrap naturally.
  - `mem_cnt` = `wr_ptr` − `rd_ptr`.
  - Full when `mem_cnt`==D; empty when `mem_cnt`==0.
- Write path:
  - push = `data_in_valid` & `data_in_ready`.
  - `data_in_ready` = ~mem_full & ~`flush`.
- Read pipeline:
  - RD_LAT stages, each with a valid bit. Stage 1 is the storage output register.
- Output buffer (OB):
  - register FIFO of OB = RD_LAT+1 entries;
  - `data_out` is the OB head;
  - `data_out_valid` = ob_not_empty & ~`flush`.
- Credits:
  - `ob_cnt` = words in the pipeline plus words in the OB, range 0..OB.
  - pop = `data_out_valid` & `data_out_ready`.
  - rd_en = ~mem_empty & ((`ob_cnt` < OB) | pop).
  - `ob_cnt` next = `ob_cnt` + rd_en − pop.
  - Rule: the OB never overflows, and throughput is 1 word/cycle with `data_out_ready` held high, for any RD_LAT.
- Level tracking:
  - `level` next = `level` + push − pop.
  - `almost_full` and `almost_empty` are recomputed from `level` next and registered, so there is no combinational path from the inputs to the flags.
- Flush:
  - In the flush cycle, `data_in_ready`=0 and `data_out_valid`=0, so no handshakes occur.
  - On the next edge all pointers, counts and valids clear to their reset values.
  - Words in flight in the read pipeline are discarded.
- Boundary conditions:
  - Push and pop in the same cycle with the FIFO full: the push is refused, because `data_in_ready` reflects storage full, not total level.
  - Push and pop in the same cycle otherwise: both occur and `level` is unchanged.
  - Push into empty storage and rd_en are never in the same cycle, because rd_en uses the registered `mem_cnt`.
  - Reset asserted mid-transfer: all state clears immediately (asynchronous) and in-flight words are lost.

## Timing
- First-word latency: push at edge E, then `data_out_valid` goes high after edge E+1+RD_LAT. Example: RD_LAT=1 gives valid 2 cycles after the push edge.
- `data_out` and `data_out_valid` change only on clock edges, except for the combinational gating by `flush`.
- Total capacity is D+OB words. `level` can exceed D.
- A pop frees an OB credit the same cycle, so rd_en may fire in the same cycle as the pop.

## Structure
- Package `sync_fifo_pkg` holds:
  - the `clog2` function;
  - `RD_LAT_MAX`=3;
  - `OB_MAX`=RD_LAT_MAX+1.
- Sub-module `prefetch_obuf`, parameters W and OB: register FIFO with push/pop/head and an empty flag, no full output (credit-protected).
- The top level holds the storage array, the read pipeline, the credit counter and the level/flag logic.

## Test plan
- Reset, then push 0x00001..0x00004 with `data_out_ready`=1, RD_LAT=1:
  - first `data_out_valid` 2 cycles after the first push;
  - words appear in order, one per cycle;
  - `level` returns to 0.
- RD_LAT=3, `data_out_ready`=0, push 10 words:
  - `level`=10;
  - exactly 4 words are read from storage (`ob_cnt`=4);
  - raising ready drains 10 words back-to-back with no bubble.
- D=8, fill until `data_in_ready`=0:
  - `level`=8+OB;
  - `almost_full` is high from `level` ≥ `AF_LEVEL`;
  - a held `data_in_valid` is not accepted.
- Simultaneous push and pop for 50 cycles with random data: `level` stays constant and the output matches the scoreboard.
- Assert `flush` with 6 words held and 2 in flight:
  - no handshake occurs in the flush cycle;
  - the next cycle shows `level`=0, `data_out_valid`=0, `almost_empty`=1;
  - the next pushed word emerges with first-word latency.
- Deassert `rst_n` asynchronously mid-burst: outputs return to reset values without waiting for a clock edge, and normal operation resumes after release.
